// File: rtl/cla_bist.sv
// BIST controller for a registered carry-lookahead adder: sweeps every operand pair and checks every result.
// Latency: vector k is driven after edge s+k and checked at edge s+k+LATENCY+1. done rises after edge s+2^(2W)+LATENCY+1.
// Backpressure: none. Vectors issue one per cycle, and start is ignored while busy.
module cla_bist #(
   parameter int WIDTH   = 5,
   parameter int LATENCY = 2   // must be >= 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [WIDTH-1:0]     a_out,
   output logic [WIDTH-1:0]     b_out,
   input  logic [WIDTH-1:0]     sum_in,
   input  logic                 cout_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     err_count,
   output logic                 fail_valid,
   output logic [WIDTH-1:0]     fail_a,
   output logic [WIDTH-1:0]     fail_b,
   output logic [WIDTH:0]       fail_obs
);

   localparam int IDX_W = 2 * WIDTH;
   // One stage for the adder input register, LATENCY-1 internal stages, and one for our own sample.
   localparam int DEPTH = LATENCY + 1;

   typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;

   // Expected-result delay line, aligned to the adder pipeline.
   logic [DEPTH-1:0]   dl_vld;
   logic [WIDTH-1:0]   dl_a   [DEPTH];
   logic [WIDTH-1:0]   dl_b   [DEPTH];
   logic [WIDTH:0]     dl_exp [DEPTH];

   logic               launch;     // start accepted this cycle
   logic               issue;      // a vector is driven onto the bus at this edge
   logic [IDX_W-1:0]   nxt_idx;
   logic [WIDTH-1:0]   nxt_a;
   logic [WIDTH-1:0]   nxt_b;
   logic [WIDTH:0]     obs;
   logic               mismatch;

   assign obs      = {cout_in, sum_in};
   assign mismatch = dl_vld[DEPTH-1] && (obs != dl_exp[DEPTH-1]);
   assign nxt_a    = nxt_idx[IDX_W-1:WIDTH];
   assign nxt_b    = nxt_idx[WIDTH-1:0];

   // Pick the next vector. The bus idles at zero when nothing issues.
   always_comb begin
      launch  = 1'b0;
      issue   = 1'b0;
      nxt_idx = '0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               launch = 1'b1;
               issue  = 1'b1;
            end
         end
         DRIVE: begin
            if (idx != '1) begin
               issue   = 1'b1;
               nxt_idx = idx + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Sweep sequencer with registered operand and status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         a_out <= '0;
         b_out <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         a_out <= nxt_a;
         b_out <= nxt_b;
         if (issue) idx <= nxt_idx;
         case (state)
            IDLE, DONE: begin
               if (launch) begin
                  state <= DRIVE;
                  busy  <= 1'b1;
                  done  <= 1'b0;
                  pass  <= 1'b0;
               end
            end
            DRIVE: begin
               if (idx == '1) state <= DRAIN;
            end
            DRAIN: begin
               // Leave once the last valid entry has been compared.
               if (dl_vld == '0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Shift the expected values along so they meet the matching adder result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            dl_a[i]   <= '0;
            dl_b[i]   <= '0;
            dl_exp[i] <= '0;
         end
      end else begin
         dl_vld    <= {dl_vld[DEPTH-2:0], issue};
         dl_a[0]   <= nxt_a;
         dl_b[0]   <= nxt_b;
         dl_exp[0] <= {1'b0, nxt_a} + {1'b0, nxt_b};
         for (int i = 1; i < DEPTH; i++) begin
            dl_a[i]   <= dl_a[i-1];
            dl_b[i]   <= dl_b[i-1];
            dl_exp[i] <= dl_exp[i-1];
         end
      end
   end

   // Count mismatches and freeze the first failing vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_obs   <= '0;
      end else if (launch) begin
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_obs   <= '0;
      end else if (mismatch) begin
         err_count <= err_count + 1'b1;
         if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= dl_a[DEPTH-1];
            fail_b     <= dl_b[DEPTH-1];
            fail_obs   <= obs;
         end
      end
   end

endmodule

// File: tb/tb_cla_bist.sv
// Bench for cla_bist: a behavioural adder with selectable faults and depth, checked against a sweep-level model.
// Latency: a full sweep takes 1027 edges from start to done.
// Backpressure: none. Every wait is bounded by a cycle budget.
module tb_cla_bist;

   localparam int W = 5;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [W-1:0]    a_out, b_out, sum_in;
   logic            cout_in;
   logic            busy, done, pass, fail_valid;
   logic [2*W:0]    err_count;
   logic [W-1:0]    fail_a, fail_b;
   logic [W:0]      fail_obs;

   int n_tests = 0;
   int n_fail  = 0;

   int mode   = 0;   // 0 good, 1 sum[2] stuck-at-0, 2 cout stuck-at-0
   int stages = 2;   // register stages in the adder model

   logic [W-1:0] a_r, b_r;
   logic [W:0]   r1, r2;

   cla_bist #(.WIDTH(W), .LATENCY(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_out(a_out), .b_out(b_out), .sum_in(sum_in), .cout_in(cout_in),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b), .fail_obs(fail_obs)
   );

   always #5 clk = ~clk;

   function automatic logic [W:0] faulty_add(input logic [W-1:0] a, input logic [W-1:0] b, input int m);
      int s;
      s = int'(a) + int'(b);
      if (m == 1) s = s & ~4;
      if (m == 2) s = s % 32;
      return s[W:0];
   endfunction

   // Adder under test: 1- or 2-stage registered adder, optionally faulty.
   always @(posedge clk) begin
      a_r <= a_out;
      b_r <= b_out;
      r1  <= faulty_add(a_out, b_out, mode);
      r2  <= faulty_add(a_r, b_r, mode);
   end
   assign {cout_in, sum_in} = (stages == 2) ? r2 : r1;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Sweep-level reference: what the BIST should report for a given adder.
   task automatic model(input int m, input int st, output int e_cnt, output int f_vld,
                        output int f_a, output int f_b, output int f_obs);
      int a, b, j, ov;
      e_cnt = 0; f_vld = 0; f_a = 0; f_b = 0; f_obs = 0;
      for (int k = 0; k < 1024; k++) begin
         a  = k / 32;
         b  = k % 32;
         j  = k + (2 - st);               // a shallower adder shows a later vector's result
         ov = (j < 1024) ? (j / 32 + j % 32) : 0;
         if (m == 1) ov = ov & ~4;
         if (m == 2) ov = ov % 32;
         if (ov != a + b) begin
            e_cnt++;
            if (f_vld == 0) begin
               f_vld = 1; f_a = a; f_b = b; f_obs = ov;
            end
         end
      end
   endtask

   task automatic run_sweep(input int m, input int st, input bit inj);
      int busy_cnt, done_at, vec_bad;
      int e_cnt, f_vld, f_a, f_b, f_obs;
      mode = m; stages = st;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("launch_a", a_out, 0);
      chk("launch_b", b_out, 0);
      chk("launch_busy", busy, 1);
      chk("launch_done", done, 0);
      chk("launch_err", err_count, 0);
      chk("launch_fvld", fail_valid, 0);
      busy_cnt = 0; done_at = 0; vec_bad = 0;
      for (int n = 1; n <= 1200 && done_at == 0; n++) begin
         start = inj && (n == 10 || n == 1026);
         @(posedge clk); #1;
         start = 1'b0;
         if (n <= 1023) begin
            if (a_out != W'(n / 32) || b_out != W'(n % 32)) vec_bad++;
         end else if (a_out != 0 || b_out != 0) begin
            vec_bad++;
         end
         if (busy) busy_cnt++;
         if (done) done_at = n;
      end
      model(m, st, e_cnt, f_vld, f_a, f_b, f_obs);
      chk("done_edge", done_at, 1027);
      chk("busy_cycles", busy_cnt, 1026);
      chk("vector_seq", vec_bad, 0);
      chk("busy_end", busy, 0);
      chk("err_count", err_count, e_cnt);
      chk("pass", pass, (e_cnt == 0) ? 1 : 0);
      chk("fail_valid", fail_valid, f_vld);
      chk("fail_a", fail_a, f_a);
      chk("fail_b", fail_b, f_b);
      chk("fail_obs", fail_obs, f_obs);
   endtask

   initial begin
      #12;
      chk("rst_outputs", {a_out, b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b, fail_obs}, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("idle_busy", busy, 0);

      // Clean adder
      run_sweep(0, 2, 0);
      chk("clean_err_const", err_count, 0);
      // sum[2] stuck at 0
      run_sweep(1, 2, 0);
      chk("s2_err_const", err_count, 512);
      chk("s2_fail_b_const", fail_b, 4);
      // cout stuck at 0, with start pulses in DRIVE and DRAIN
      run_sweep(2, 2, 1);
      chk("cout_err_const", err_count, 496);
      chk("cout_fail_a_const", fail_a, 1);
      // Single-stage adder against a two-stage expectation
      run_sweep(0, 1, 0);
      chk("lat_err_nonzero", (err_count != 0) ? 1 : 0, 1);
      chk("lat_fail_obs_const", fail_obs, 1);

      // Reset mid-run, with a faulty adder so any stale compare would be counted
      mode = 1; stages = 2;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (500) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_rst_outputs", {a_out, b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b, fail_obs}, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("post_rst_err", err_count, 0);
      chk("post_rst_fvld", fail_valid, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_done", done, 0);
      run_sweep(0, 2, 0);

      // Randomised operating point
      begin
         int rm;
         rm = int'($urandom_range(2, 0));
         run_sweep(rm, 2, 1'($urandom_range(1, 0)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
